// File: rtl/common_fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_arb_pkg
// Brief    : Shared constants and helpers for the FIFO write-side arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package common_fifo_arb_pkg;

    localparam int ARB_PORTS_MAX  = 16;
    localparam int ARB_LOCK_CNT_W = 8;

    // Index width for a given port count; never collapses below one bit.
    function automatic int grant_id_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/common_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : common_arbiter_rr_pick
// Brief    : Combinational round-robin pick: rotate by rr_ptr, priority-encode,
//            rotate the found offset back to an absolute index.
// Revision : 1.0 - initial release
// ============================================================================
module common_arbiter_rr_pick
    import common_fifo_arb_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]                 req,
    input  logic [grant_id_width(PORTS)-1:0] rr_ptr,
    output logic [PORTS-1:0]                 gnt,
    output logic [grant_id_width(PORTS)-1:0] gnt_id,
    output logic                             gnt_vld
);

    localparam int ID_W = grant_id_width(PORTS);

    logic [PORTS-1:0] w_req_rot;
    logic [ID_W-1:0]  w_offset;
    logic [ID_W:0]    w_sum;
    logic             w_found;
    int               w_src;

    always_comb begin
        w_req_rot = '0;
        w_src     = 0;
        for (int i = 0; i < PORTS; i++) begin
            w_src = int'(rr_ptr) + i;
            if (w_src >= PORTS) begin
                w_src = w_src - PORTS;
            end
            w_req_rot[i] = req[w_src];
        end

        w_offset = '0;
        w_found  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (!w_found && w_req_rot[i]) begin
                w_found  = 1'b1;
                w_offset = ID_W'(i);
            end
        end

        // One extra bit so the wrap back into 0..PORTS-1 is exact.
        w_sum = {1'b0, rr_ptr} + {1'b0, w_offset};
        if (w_sum >= (ID_W+1)'(PORTS)) begin
            w_sum = w_sum - (ID_W+1)'(PORTS);
        end

        gnt_vld = w_found;
        gnt_id  = w_found ? w_sum[ID_W-1:0] : '0;
        gnt     = '0;
        for (int i = 0; i < PORTS; i++) begin
            gnt[i] = w_found && (w_sum[ID_W-1:0] == ID_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/common_fifo_arbiter_nw1r.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_arbiter_nw1r
// Brief    : Round-robin N-producer write arbiter in front of one 1w1r FIFO,
//            with same-cycle acknowledge. Optional burst lock enabled by
//            defining COMMON_FIFO_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module common_fifo_arbiter_nw1r
    import common_fifo_arb_pkg::*;
#(
    parameter int ARB_PORTS    = 4,
    parameter int FIFO_WIDTH   = 1,
    parameter int ARB_LOCK_MAX = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ARB_PORTS-1:0]                req,
    input  logic [ARB_PORTS*FIFO_WIDTH-1:0]     req_data,
    output logic [ARB_PORTS-1:0]                req_ack,
`ifdef COMMON_FIFO_ARB_LOCK_EN
    input  logic [ARB_PORTS-1:0]                req_lock,
`endif
    output logic [FIFO_WIDTH-1:0]               fifo_din,
    output logic                                fifo_wen,
    input  logic                                fifo_full,
    output logic [grant_id_width(ARB_PORTS)-1:0] grant_id
);

    localparam int ID_W = grant_id_width(ARB_PORTS);

    if (ARB_PORTS < 2 || ARB_PORTS > ARB_PORTS_MAX ||
        ARB_LOCK_MAX < 1 || ARB_LOCK_MAX > 255) begin : g_param_check
        $error("common_fifo_arbiter_nw1r: illegal ARB_PORTS or ARB_LOCK_MAX");
    end

    function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] id);
        return (id == ID_W'(ARB_PORTS-1)) ? '0 : id + ID_W'(1);
    endfunction

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ARB_PORTS-1:0] w_pick_gnt;
    logic [ID_W-1:0]      w_pick_id;
    logic                 w_pick_vld;
    logic                 w_grant_vld;
    logic [ID_W-1:0]      w_grant_id;
    logic [ARB_PORTS-1:0] w_grant_oh;

    common_arbiter_rr_pick #(
        .PORTS   (ARB_PORTS)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (w_pick_gnt),
        .gnt_id  (w_pick_id),
        .gnt_vld (w_pick_vld)
    );

`ifdef COMMON_FIFO_ARB_LOCK_EN
    logic                      lock_vld_q,   lock_vld_d;
    logic [ID_W-1:0]           lock_owner_q, lock_owner_d;
    logic [ARB_LOCK_CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic [ARB_PORTS-1:0]      w_owner_oh;

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < ARB_PORTS; i++) begin
            w_owner_oh[i] = (lock_owner_q == ID_W'(i));
        end
    end
`endif

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_grant_oh  = '0;
        rr_ptr_d    = rr_ptr_q;
`ifdef COMMON_FIFO_ARB_LOCK_EN
        lock_vld_d   = lock_vld_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        // A full FIFO pauses everything, including a held lock.
        if (!reset && !fifo_full) begin
            if (lock_vld_q) begin
                rr_ptr_d = ptr_next(lock_owner_q);
                if (!req[lock_owner_q]) begin
                    lock_vld_d = 1'b0;
                end else begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = lock_owner_q;
                    w_grant_oh  = w_owner_oh;
                    lock_cnt_d  = lock_cnt_q + ARB_LOCK_CNT_W'(1);
                    if (!req_lock[lock_owner_q] || int'(lock_cnt_d) >= ARB_LOCK_MAX) begin
                        lock_vld_d = 1'b0;
                    end
                end
            end else if (w_pick_vld) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_pick_id;
                w_grant_oh  = w_pick_gnt;
                rr_ptr_d    = ptr_next(w_pick_id);
                // The opening grant counts toward the limit.
                if (req_lock[w_pick_id] && ARB_LOCK_MAX > 1) begin
                    lock_vld_d   = 1'b1;
                    lock_owner_d = w_pick_id;
                    lock_cnt_d   = ARB_LOCK_CNT_W'(1);
                end
            end
        end
`else
        if (!reset && !fifo_full && w_pick_vld) begin
            w_grant_vld = 1'b1;
            w_grant_id  = w_pick_id;
            w_grant_oh  = w_pick_gnt;
            rr_ptr_d    = ptr_next(w_pick_id);
        end
`endif
    end

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < ARB_PORTS; i++) begin
            if (w_grant_oh[i]) begin
                fifo_din = fifo_din | req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign req_ack  = w_grant_oh;
    assign fifo_wen = w_grant_vld;
    assign grant_id = w_grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef COMMON_FIFO_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_common_fifo_arbiter_nw1r.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_fifo_arbiter_nw1r
// Brief    : Self-checking bench: behavioural arbiter model compared every
//            cycle, plus directed literal acknowledge expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_common_fifo_arbiter_nw1r;

    localparam int P    = 4;
    localparam int W    = 8;
    localparam int LMAX = 3;
`ifdef COMMON_FIFO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic [P-1:0]   req      = '0;
    logic [P-1:0]   req_lock = '0;
    logic [P*W-1:0] req_data;
    logic [P-1:0]   req_ack;
    logic [W-1:0]   fifo_din;
    logic           fifo_wen;
    logic           fifo_full = 1'b0;
    logic [1:0]     grant_id;

    logic         rd  = 1'b0;
    logic         clr = 1'b0;
    int           depth = 16;
    logic [W-1:0] fifo_q[$];

    int n_total = 0;
    int n_pass  = 0;

    assign req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    always #5 clk = ~clk;

    common_fifo_arbiter_nw1r #(
        .ARB_PORTS    (P),
        .FIFO_WIDTH   (W),
        .ARB_LOCK_MAX (LMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .req_ack   (req_ack),
`ifdef COMMON_FIFO_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .fifo_din  (fifo_din),
        .fifo_wen  (fifo_wen),
        .fifo_full (fifo_full),
        .grant_id  (grant_id)
    );

    // Behavioural FIFO: full flag is registered, writes ignored while full.
    always @(posedge clk) begin
        if (clr) begin
            fifo_q.delete();
        end else begin
            if (fifo_wen && !fifo_full) fifo_q.push_back(fifo_din);
            if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        fifo_full <= clr ? 1'b0 : (fifo_q.size() >= depth);
    end

    // Arbiter model state: pointer, lock owner, consecutive locked grants.
    int           m_rr = 0, m_owner = 0, m_cnt = 0;
    bit           m_lock = 1'b0;
    int           n_rr, n_owner, n_cnt;
    bit           n_lock;
    logic [P-1:0] e_ack;
    int           e_id;
    bit           e_v;
    logic [W-1:0] e_din;

    always @(negedge clk) begin
        e_ack = '0; e_id = 0; e_v = 1'b0;
        n_rr = m_rr; n_lock = m_lock; n_owner = m_owner; n_cnt = m_cnt;
        if (reset) begin
            n_rr = 0; n_lock = 1'b0; n_owner = 0; n_cnt = 0;
        end else if (!fifo_full) begin
            if (m_lock) begin
                n_rr = (m_owner + 1) % P;
                if (!req[m_owner]) begin
                    n_lock = 1'b0;
                end else begin
                    e_v = 1'b1; e_id = m_owner; n_cnt = m_cnt + 1;
                    if (!req_lock[m_owner] || n_cnt >= LMAX) n_lock = 1'b0;
                end
            end else begin
                for (int k = 0; k < P; k++) begin
                    if (!e_v && req[(m_rr + k) % P]) begin
                        e_v = 1'b1; e_id = (m_rr + k) % P;
                    end
                end
                if (e_v) begin
                    n_rr = (e_id + 1) % P;
                    if (LOCK_EN && req_lock[e_id] && LMAX > 1) begin
                        n_lock = 1'b1; n_owner = e_id; n_cnt = 1;
                    end
                end
            end
        end
        if (e_v) e_ack[e_id] = 1'b1;
        e_din = e_v ? req_data[e_id*W +: W] : '0;
        n_total++;
        if (req_ack !== e_ack || fifo_wen !== e_v || grant_id !== e_id[1:0] || fifo_din !== e_din)
            $display("FAIL model_cmp t=%0t: ack=%b wen=%b id=%0d din=%h, required ack=%b wen=%b id=%0d din=%h",
                     $time, req_ack, fifo_wen, grant_id, fifo_din, e_ack, e_v, e_id, e_din);
        else
            n_pass++;
    end

    always @(posedge clk) begin
        m_rr <= n_rr; m_lock <= n_lock; m_owner <= n_owner; m_cnt <= n_cnt;
    end

    // One cycle of stimulus plus a hand-computed literal acknowledge check.
    task automatic step(input logic rs, input logic [P-1:0] r, input logic [P-1:0] l,
                        input logic rd_i, input logic [P-1:0] exp, input string nm);
        int exp_id;
        @(posedge clk);
        #1;
        reset = rs; req = r; req_lock = l; rd = rd_i;
        #2;
        exp_id = 0;
        for (int k = 0; k < P; k++) if (exp[k]) exp_id = k;
        n_total++;
        if (req_ack !== exp || fifo_wen !== (exp != '0) || grant_id !== exp_id[1:0])
            $display("FAIL %s: ack=%b wen=%b id=%0d, required ack=%b wen=%b id=%0d",
                     nm, req_ack, fifo_wen, grant_id, exp, (exp != '0), exp_id);
        else
            n_pass++;
    endtask

    task automatic flush();
        clr = 1'b1;
        step(1'b0, '0, '0, 1'b0, '0, "flush");
        clr = 1'b0;
    endtask

    logic [W-1:0] exp_byte;

    initial begin
        step(1'b1, '0, '0, 1'b0, '0, "reset0");
        step(1'b1, '0, '0, 1'b0, '0, "reset1");
        for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b0, '0, "idle");

        // Fairness: all four request continuously.
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0001, "fair0");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0010, "fair1");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0100, "fair2");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b1000, "fair3");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0001, "fair4");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0010, "fair5");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0100, "fair6");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b1000, "fair7");
        step(1'b0, '0, '0, 1'b0, '0, "fair_end");
        n_total++;
        if (fifo_q.size() !== 8) $display("FAIL fifo_count: got %0d, required 8", fifo_q.size());
        else n_pass++;
        for (int k = 0; k < fifo_q.size(); k++) begin
            exp_byte = 8'hA0 + 8'(k % 4);
            n_total++;
            if (fifo_q[k] !== exp_byte)
                $display("FAIL fifo_data[%0d]: got %h, required %h", k, fifo_q[k], exp_byte);
            else
                n_pass++;
        end
        flush();

        // Backpressure with a two-entry FIFO and no reads.
        depth = 2;
        step(1'b0, 4'b0011, '0, 1'b0, 4'b0001, "bp_ack0");
        step(1'b0, 4'b0011, '0, 1'b0, 4'b0010, "bp_ack1");
        step(1'b0, 4'b0011, '0, 1'b0, 4'b0000, "bp_full0");
        step(1'b0, 4'b0011, '0, 1'b0, 4'b0000, "bp_full1");
        step(1'b0, 4'b0011, '0, 1'b1, 4'b0000, "bp_read");
        step(1'b0, 4'b0011, '0, 1'b0, 4'b0001, "bp_after_read");
        step(1'b0, '0, '0, 1'b0, '0, "bp_end");
        flush();
        depth = 16;

        // Sparse: pointer sits at 2 after a grant to port 1.
        step(1'b0, 4'b0010, '0, 1'b0, 4'b0010, "sparse_p1");
        step(1'b0, 4'b0001, '0, 1'b0, 4'b0001, "sparse_wrap");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0010, "sparse_ptr1");
        step(1'b0, '0, '0, 1'b0, '0, "sparse_end");

`ifdef COMMON_FIFO_ARB_LOCK_EN
        step(1'b0, 4'b0010, '0, 1'b0, 4'b0010, "lock_setup");
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, "lock_g1");
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, "lock_g2");
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0100, "lock_g3");
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 4'b1000, "lock_rel3");
        step(1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0001, "lock_rel0");
        step(1'b0, '0, '0, 1'b0, '0, "lock_end");
`endif

        // Reset mid-stream (lock held by port 1 when the lock build is used).
        step(1'b0, 4'b0001, '0, 1'b0, 4'b0001, "rst_setup");
        step(1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0010, "rst_pre0");
        step(1'b0, 4'b1111, 4'b0010, 1'b0, LOCK_EN ? 4'b0010 : 4'b0100, "rst_pre1");
        step(1'b1, 4'b1111, 4'b0010, 1'b0, 4'b0000, "rst_during");
        step(1'b0, 4'b1111, '0, 1'b0, 4'b0001, "rst_after");
        step(1'b0, '0, '0, 1'b0, '0, "final_idle");
        step(1'b0, '0, '0, 1'b0, '0, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
